// File: rtl/cn_ctrl_pkg.sv
// Shared constants and FSM encoding for the CN LUT iteration refresh controller.
`timescale 1ns/1ps
package cn_ctrl_pkg;

  localparam int DEF_CN_LOAD_CYCLE  = 32;
  localparam int DEF_ITER_ROM_GROUP = 25;
  localparam int DEF_MAX_ITER       = 50;
  localparam int DEF_PAGE_ADDR_BW   = 5;
  localparam int DEF_ITER_ADDR_BW   = 6;
  localparam int DEF_ROM_ADDR_BW    = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_FILL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } cn_state_e;

endpackage

// File: rtl/cn_iter_update_ctrl_if.sv
// Decoder request / CN memory load bundle; master is the decoder side, slave the controller.
`timescale 1ns/1ps
interface cn_iter_update_ctrl_if
  import cn_ctrl_pkg::*;
#(
  parameter int PAGE_ADDR_BW = DEF_PAGE_ADDR_BW,
  parameter int ITER_ADDR_BW = DEF_ITER_ADDR_BW,
  parameter int ROM_ADDR_BW  = DEF_ROM_ADDR_BW
) ();

  logic                    update_req;
  logic                    decode_term;
  logic                    rom_port_fetch;
  logic [ROM_ADDR_BW-1:0]  rom_base_addr;
  logic                    iter_switch;
  logic                    wr_en;
  logic [PAGE_ADDR_BW-1:0] wr_page_addr;
  logic [ITER_ADDR_BW-1:0] iter_cnt;
  logic                    busy;
  logic                    update_done;
  logic                    all_iter_done;

  modport master (
    output update_req, decode_term,
    input  rom_port_fetch, rom_base_addr, iter_switch, wr_en, wr_page_addr,
           iter_cnt, busy, update_done, all_iter_done
  );

  modport slave (
    input  update_req, decode_term,
    output rom_port_fetch, rom_base_addr, iter_switch, wr_en, wr_page_addr,
           iter_cnt, busy, update_done, all_iter_done
  );

endinterface

// File: rtl/cn_page_counter.sv
// CN memory page address counter: sync clear, enable, terminal-count flag at the last page.
`timescale 1ns/1ps
module cn_page_counter
  import cn_ctrl_pkg::*;
#(
  parameter int CN_LOAD_CYCLE = DEF_CN_LOAD_CYCLE,
  parameter int PAGE_ADDR_BW  = DEF_PAGE_ADDR_BW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  output logic [PAGE_ADDR_BW-1:0] count,
  output logic                    tc
);

  logic [PAGE_ADDR_BW-1:0] count_q;
  logic [PAGE_ADDR_BW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + PAGE_ADDR_BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == PAGE_ADDR_BW'(CN_LOAD_CYCLE - 1));

endmodule

// File: rtl/cn_iter_update_ctrl.sv
// Sequences one CN LUT refresh per decoder request: ROM fetch, fill latency, page writes, done,
// and tracks the completed-iteration count that selects the IB-ROM group and base address.
`timescale 1ns/1ps
module cn_iter_update_ctrl
  import cn_ctrl_pkg::*;
#(
  parameter int CN_LOAD_CYCLE  = DEF_CN_LOAD_CYCLE,
  parameter int ITER_ROM_GROUP = DEF_ITER_ROM_GROUP,
  parameter int MAX_ITER       = DEF_MAX_ITER,
  parameter int PAGE_ADDR_BW   = DEF_PAGE_ADDR_BW,
  parameter int ITER_ADDR_BW   = DEF_ITER_ADDR_BW,
  parameter int ROM_ADDR_BW    = DEF_ROM_ADDR_BW
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  cn_iter_update_ctrl_if.slave  bus
);

  cn_state_e               state_q, state_d;
  logic                    fill_cnt_q, fill_cnt_d;
  logic [ITER_ADDR_BW-1:0] iter_cnt_q, iter_cnt_d;
  logic                    iter_switch_q, iter_switch_d;
  logic [ROM_ADDR_BW-1:0]  rom_base_q, rom_base_d;

  logic                    all_done;
  logic                    start;
  logic                    grp_sel;
  logic [ITER_ADDR_BW-1:0] local_iter;
  logic [PAGE_ADDR_BW-1:0] page_addr;
  logic                    page_tc;
  logic                    page_en;
  logic                    page_clr;

  assign all_done   = (iter_cnt_q == ITER_ADDR_BW'(MAX_ITER));
  assign start      = (state_q == ST_IDLE) && (state_d == ST_FETCH);
  assign grp_sel    = (iter_cnt_q >= ITER_ADDR_BW'(ITER_ROM_GROUP));
  assign local_iter = grp_sel ? (iter_cnt_q - ITER_ADDR_BW'(ITER_ROM_GROUP)) : iter_cnt_q;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Termination outranks everything, including a request arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (bus.decode_term) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.update_req && !all_done) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_FILL;
        ST_FILL:  if (fill_cnt_q) state_d = ST_WRITE;
        ST_WRITE: if (page_tc) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rom_port_fetch = 1'b1;
    bus.wr_en          = 1'b0;
    bus.busy           = 1'b1;
    bus.update_done    = 1'b0;
    case (state_q)
      ST_IDLE:  bus.busy           = 1'b0;
      ST_FETCH: bus.rom_port_fetch = 1'b0;
      ST_WRITE: bus.wr_en          = 1'b1;
      ST_DONE:  bus.update_done    = 1'b1;
      default:  ;
    endcase
  end

  // ROM group and base address are captured once per refresh so they hold from FETCH to DONE.
  always_comb begin
    fill_cnt_d    = (state_q == ST_FILL) && !fill_cnt_q;
    iter_cnt_d    = iter_cnt_q;
    iter_switch_d = iter_switch_q;
    rom_base_d    = rom_base_q;
    if (bus.decode_term) begin
      iter_cnt_d = '0;
    end else if ((state_q == ST_DONE) && !all_done) begin
      iter_cnt_d = iter_cnt_q + ITER_ADDR_BW'(1);
    end
    if (start) begin
      iter_switch_d = grp_sel;
      rom_base_d    = ROM_ADDR_BW'(local_iter) * ROM_ADDR_BW'(CN_LOAD_CYCLE);
    end
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      fill_cnt_q    <= 1'b0;
      iter_cnt_q    <= '0;
      iter_switch_q <= 1'b0;
      rom_base_q    <= '0;
    end else begin
      fill_cnt_q    <= fill_cnt_d;
      iter_cnt_q    <= iter_cnt_d;
      iter_switch_q <= iter_switch_d;
      rom_base_q    <= rom_base_d;
    end
  end

  // The page address is cleared only on the edge into WRITE and freezes at the last page written.
  assign page_clr = (state_q == ST_FILL) && (state_d == ST_WRITE);
  assign page_en  = (state_q == ST_WRITE) && !page_tc && !bus.decode_term;

  cn_page_counter #(
    .CN_LOAD_CYCLE (CN_LOAD_CYCLE),
    .PAGE_ADDR_BW  (PAGE_ADDR_BW)
  ) u_page_counter (
    .clk   (write_clk),
    .rst_n (rstn),
    .en    (page_en),
    .clr   (page_clr),
    .count (page_addr),
    .tc    (page_tc)
  );

  assign bus.rom_base_addr = rom_base_q;
  assign bus.iter_switch   = iter_switch_q;
  assign bus.wr_page_addr  = page_addr;
  assign bus.iter_cnt      = iter_cnt_q;
  assign bus.all_iter_done = all_done;

endmodule

// File: doc/cn_iter_update_ctrl.md
CN_ITER_UPDATE_CTRL -- requirements
Module: cn_iter_update_ctrl

Interface
REQ-001 SHALL take parameter CN_LOAD_CYCLE, default 32: number of pages written per iteration refresh.
REQ-002 SHALL take parameter ITER_ROM_GROUP, default 25: number of iterations stored per IB-ROM group.
REQ-003 SHALL take parameter MAX_ITER, default 50: total number of iterations.
REQ-004 SHALL take parameter PAGE_ADDR_BW, default 5; ITER_ADDR_BW, default 6; ROM_ADDR_BW, default 10.
REQ-005 SHALL have write_clk, input, 1: single clock, rising edge.
REQ-006 SHALL have rstn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have update_req, input, 1: decoder request to refresh the CN LUT for the next iteration; level-sampled.
REQ-008 SHALL have decode_term, input, 1: early termination/abort from decoder.
REQ-009 SHALL have rom_port_fetch, output, 1: active-low reload strobe to the CN memory latches; low loads the base address.
REQ-010 SHALL have rom_base_addr, output, ROM_ADDR_BW: IB-ROM base address for the current iteration.
REQ-011 SHALL have iter_switch, output, 1: ROM group select; 1 when iter_cnt >= ITER_ROM_GROUP.
REQ-012 SHALL have wr_en, output, 1 and wr_page_addr, output, PAGE_ADDR_BW: CN memory page write strobe and page address.
REQ-013 SHALL have iter_cnt, output, ITER_ADDR_BW: completed-refresh count.
REQ-014 SHALL have busy, output, 1; update_done, output, 1 (one-cycle pulse); all_iter_done, output, 1 (iter_cnt == MAX_ITER).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, FILL, WRITE, DONE.
REQ-016 IDLE: on update_req=1, decode_term=0, all_iter_done=0 SHALL go to FETCH; otherwise SHALL stay in IDLE.
REQ-017 FETCH SHALL last 1 cycle with rom_port_fetch=0; in all other states rom_port_fetch SHALL be 1.
REQ-018 FILL SHALL last exactly 2 cycles, covering ROM read latency plus latch register, then SHALL go to WRITE.
REQ-019 WRITE SHALL assert wr_en for exactly CN_LOAD_CYCLE consecutive cycles; wr_page_addr SHALL be 0 on the first cycle and increment by 1 each cycle up to CN_LOAD_CYCLE-1.
REQ-020 After the last WRITE cycle SHALL enter DONE for 1 cycle: update_done=1; iter_cnt SHALL increment by 1 at the end of DONE; next state IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 rom_base_addr SHALL equal local_iter*CN_LOAD_CYCLE, where local_iter = iter_cnt when iter_switch=0, and iter_cnt-ITER_ROM_GROUP otherwise; it SHALL be registered and stable from FETCH through DONE.
REQ-023 iter_switch SHALL be registered from iter_cnt and valid in FETCH.
REQ-024 update_req while busy=1 SHALL be ignored; a level still high in IDLE SHALL start a new refresh with no bubble beyond 1 IDLE cycle.
REQ-025 When iter_cnt == MAX_ITER: all_iter_done=1, update_req SHALL be ignored, and iter_cnt SHALL saturate and never wrap.
REQ-026 decode_term=1 in any state SHALL force IDLE on the next edge: wr_en=0, no update_done, iter_cnt cleared to 0; decode_term outranks a simultaneous update_req.
REQ-027 wr_page_addr SHALL hold its last value outside WRITE and SHALL reset to 0 on entry to WRITE.

Reset
REQ-028 On rstn=0 asynchronously: state=IDLE, rom_port_fetch=1, rom_base_addr=0, iter_switch=0, wr_en=0, wr_page_addr=0, iter_cnt=0, busy=0, update_done=0, all_iter_done=0.
REQ-029 Reset mid-WRITE SHALL terminate the write immediately; after release the block SHALL wait in IDLE for update_req.

Structure
REQ-030 CN_LOAD_CYCLE, ITER_ROM_GROUP, MAX_ITER, the bit-widths and the FSM state encoding SHALL live in shared package cn_ctrl_pkg.
REQ-031 The page counter SHALL be one sub-module, cn_page_counter (enable, sync clear, terminal-count flag); the FSM and iteration counter SHALL remain in the top module.

Verification
REQ-032 Bench SHALL cover: reset, then a single update_req pulse -> FETCH at cycle 1, FILL cycles 2-3, wr_en cycles 4-35 with pages 0..31, update_done at cycle 36, iter_cnt=1, rom_base_addr=0.
REQ-033 Bench SHALL cover: iter_cnt=24 -> 25 -> next refresh gives iter_switch=1 and rom_base_addr=0; at iter_cnt=26, rom_base_addr=32.
REQ-034 Bench SHALL cover: 50 refreshes -> all_iter_done=1; a further update_req gives busy=0 and iter_cnt=50.
REQ-035 Bench SHALL cover: decode_term at WRITE page 10 -> wr_en=0 on the next cycle, no update_done, iter_cnt=0.
REQ-036 Bench SHALL cover: update_req held high -> back-to-back refreshes 37 cycles apart, with update_req ignored during busy.
REQ-037 Bench SHALL cover: rstn asserted mid-FILL -> all outputs at reset values within the same cycle, asynchronously.
